// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store initiator: funct3 codes, FSM state
// encoding and the request legality check.
package lsu_mem_ctrl_pkg;

  localparam int unsigned MEM_WORDS_DEF = 256;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  // Misalignment, illegal funct3 (unsigned widths are loads only) or out of range.
  function automatic logic lsu_req_err(input logic        we,
                                       input logic [2:0]  funct3,
                                       input logic [31:0] addr,
                                       input logic [31:0] limit);
    logic bad;
    case (funct3)
      LSU_B:   bad = 1'b0;
      LSU_H:   bad = addr[0];
      LSU_W:   bad = (addr[1:0] != 2'b00);
      LSU_BU:  bad = we;
      LSU_HU:  bad = we | addr[0];
      default: bad = 1'b1;
    endcase
    return bad | (addr >= limit);
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Lane handling between a memory word and the core: extract+extend for loads,
// byte/halfword merge into the read word for sub-word stores.
module lsu_lane_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection from the read word
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (addr_lo_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
  end

  // Sign/zero extension of the selected lane
  always_comb begin
    load_data_o = 32'h0000_0000;
    case (funct3_i)
      LSU_B:   load_data_o = {{24{byte_s[7]}}, byte_s};
      LSU_BU:  load_data_o = {24'h00_0000, byte_s};
      LSU_H:   load_data_o = {{16{half_s[15]}}, half_s};
      LSU_HU:  load_data_o = {16'h0000, half_s};
      LSU_W:   load_data_o = rdata_i;
      default: load_data_o = 32'h0000_0000;
    endcase
  end

  // Store merge: replace only the addressed lane of the read word
  always_comb begin
    merged_o = rdata_i;
    case (funct3_i)
      LSU_B: begin
        case (addr_lo_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          2'd3:    merged_o[31:24] = wdata_i[7:0];
          default: merged_o = rdata_i;
        endcase
      end
      LSU_H: begin
        if (addr_lo_i[1]) begin
          merged_o[31:16] = wdata_i;
        end else begin
          merged_o[15:0] = wdata_i;
        end
      end
      default: merged_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and a word-wide data memory.
// One response per accepted request; sub-word stores become read-modify-write.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic [31:0] mem_raddr_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  lsu_state_e  state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [15:0] wdata_lo_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] mem_raddr_q;
  logic [31:0] mem_waddr_q;
  logic [31:0] mem_wdata_q;

  logic        req_err_d;
  logic [31:0] word_addr_d;
  logic [31:0] load_data_s;
  logic [31:0] merged_s;

  assign req_err_d   = lsu_req_err(req_we_i, req_funct3_i, req_addr_i, ADDR_LIMIT);
  assign word_addr_d = {req_addr_i[31:2], 2'b00};

  lsu_lane_align u_lane_align (
    .funct3_i    (funct3_q),
    .addr_lo_i   (addr_lo_q),
    .rdata_i     (mem_rdata_i),
    .wdata_i     (wdata_lo_q),
    .load_data_o (load_data_s),
    .merged_o    (merged_s)
  );

  // Control FSM together with request capture and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      wdata_lo_q  <= 16'h0000;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      mem_raddr_q <= 32'h0000_0000;
      mem_waddr_q <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            funct3_q    <= req_funct3_i;
            addr_lo_q   <= req_addr_i[1:0];
            wdata_lo_q  <= req_wdata_i[15:0];
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= req_err_d;
            // Erroneous requests never touch the memory address/data registers
            if (req_err_d) begin
              state_q <= ST_RESP;
            end else if (!req_we_i) begin
              mem_raddr_q <= word_addr_d;
              state_q     <= ST_LOAD;
            end else if (req_funct3_i == LSU_W) begin
              mem_waddr_q <= word_addr_d;
              mem_wdata_q <= req_wdata_i;
              state_q     <= ST_WRITE;
            end else begin
              mem_raddr_q <= word_addr_d;
              mem_waddr_q <= word_addr_d;
              state_q     <= ST_MERGE;
            end
          end
        end
        ST_LOAD: begin
          rsp_rdata_q <= load_data_s;
          state_q     <= ST_RESP;
        end
        ST_MERGE: begin
          mem_wdata_q <= merged_s;
          state_q     <= ST_WRITE;
        end
        ST_WRITE: begin
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_req_o   = (state_q == ST_WRITE);
  assign mem_we_o    = (state_q == ST_WRITE);
  assign mem_raddr_o = mem_raddr_q;
  assign mem_waddr_o = mem_waddr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a word-array memory and a byte-level
// reference model of loads, stores, errors and latency.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_raddr_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] tb_mem  [0:255];
  logic [31:0] ref_mem [0:255];

  int total = 0;
  int bad   = 0;
  int wr_seen = 0;

  bit          exp_active = 1'b0;
  logic [31:0] exp_rdata;
  logic        exp_err;
  bit          exp_wr_pending = 1'b0;
  logic [31:0] exp_wr_addr;
  logic [31:0] exp_wr_data;

  lsu_mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_waddr_o  (mem_waddr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_raddr_o  (mem_raddr_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  assign mem_rdata_i = tb_mem[mem_raddr_o[9:2]];

  always @(posedge clk) begin
    if (mem_req_o) tb_mem[mem_waddr_o[9:2]] <= mem_wdata_o;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    if (sz == 0) return 1'b1;
    if (we && f3[2]) return 1'b1;
    if ((a % sz) != 0) return 1'b1;
    if (a >= 32'd1024) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    logic [31:0] v = ref_mem[a[9:2]] >> ((a % 4) * 8);
    if (sz == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] wd);
    logic [31:0] w = ref_mem[a[9:2]];
    for (int k = 0; k < size_of(f3); k++) w[((a % 4) + k) * 8 +: 8] = wd[k * 8 +: 8];
    return w;
  endfunction

  // Per-cycle comparison of memory-side and response-side outputs
  always @(negedge clk) begin
    if (!rst) begin
      chk("mem_we_eq_req", {31'd0, mem_we_o}, {31'd0, mem_req_o});
      if (mem_req_o) begin
        wr_seen++;
        chk("write_expected", {31'd0, exp_wr_pending}, 32'd1);
        if (exp_wr_pending) begin
          chk("mem_waddr", mem_waddr_o, exp_wr_addr);
          chk("mem_wdata", mem_wdata_o, exp_wr_data);
          exp_wr_pending = 1'b0;
        end
      end
      if (rsp_valid_o && exp_active) begin
        chk("rsp_rdata", rsp_rdata_o, exp_rdata);
        chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_err});
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_req(input string nm, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        input bit pin_en, input logic [31:0] pin);
    int exp_lat;
    int lat;
    bit got;
    exp_err   = model_err(we, f3, a);
    exp_rdata = (exp_err || we) ? 32'd0 : model_load(f3, a);
    exp_lat   = exp_err ? 1 : ((we && size_of(f3) < 4) ? 3 : 2);
    if (!exp_err && we) begin
      exp_wr_addr    = {a[31:2], 2'b00};
      exp_wr_data    = model_store(f3, a, wd);
      exp_wr_pending = 1'b1;
      ref_mem[a[9:2]] = exp_wr_data;
    end
    exp_active = 1'b1;
    chk({nm, "_ready"}, {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0; req_we_i = 1'($urandom); req_funct3_i = 3'($urandom);
    req_addr_i = $urandom; req_wdata_i = $urandom;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!got) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_latency"}, lat, exp_lat);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_hold_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        chk({nm, "_hold_ready"}, {31'd0, req_ready_o}, 32'd0);
      end
      if (pin_en) begin
        if (we) chk({nm, "_pin_mem"}, tb_mem[a[9:2]], pin);
        else    chk({nm, "_pin_rdata"}, rsp_rdata_o, pin);
      end
      chk({nm, "_write_done"}, {31'd0, exp_wr_pending}, 32'd0);
      rsp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready_i = 1'b0;
    end
    exp_active = 1'b0;
    exp_wr_pending = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_valid"}, {31'd0, rsp_valid_o}, 32'd0);
    chk({nm, "_idle_ready"}, {31'd0, req_ready_o}, 32'd1);
  endtask

  initial begin
    int wr_before;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    tb_mem[1] = 32'h8899AABB; ref_mem[1] = 32'h8899AABB;
    tb_mem[2] = 32'h11223344; ref_mem[2] = 32'h11223344;
    rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'd0;
    req_addr_i = 32'd0; req_wdata_i = 32'd0; rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst_mem_req", {30'd0, mem_req_o, mem_we_o}, 32'd0);
    chk("rst_mem_raddr", mem_raddr_o, 32'd0);
    chk("rst_mem_waddr", mem_waddr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);

    do_req("lb_5",    1'b0, 3'b000, 32'h5, 32'h0, 0, 1'b1, 32'hFFFFFFAA);
    do_req("lhu_6",   1'b0, 3'b101, 32'h6, 32'h0, 0, 1'b1, 32'h00008899);
    do_req("lh_6",    1'b0, 3'b001, 32'h6, 32'h0, 0, 1'b1, 32'hFFFF8899);
    do_req("lbu_4",   1'b0, 3'b100, 32'h4, 32'h0, 0, 1'b1, 32'h000000BB);
    do_req("lw_4",    1'b0, 3'b010, 32'h4, 32'h0, 0, 1'b1, 32'h8899AABB);
    do_req("sb_9",    1'b1, 3'b000, 32'h9, 32'h000000EE, 0, 1'b1, 32'h1122EE44);
    do_req("sh_2",    1'b1, 3'b001, 32'h2, 32'h1234ABCD, 0, 1'b1, 32'hABCD0000);
    do_req("sw_c",    1'b1, 3'b010, 32'hC, 32'hDEADBEEF, 5, 1'b1, 32'hDEADBEEF);
    do_req("lw_c",    1'b0, 3'b010, 32'hC, 32'h0, 0, 1'b1, 32'hDEADBEEF);
    do_req("lw_8",    1'b0, 3'b010, 32'h8, 32'h0, 0, 1'b1, 32'h1122EE44);
    do_req("lb_3ff",  1'b0, 3'b000, 32'h3FF, 32'h0, 0, 1'b0, 32'h0);
    do_req("err_lw2", 1'b0, 3'b010, 32'h2, 32'h0, 0, 1'b0, 32'h0);
    do_req("err_sh3", 1'b1, 3'b001, 32'h3, 32'h5555, 0, 1'b0, 32'h0);
    do_req("err_oor", 1'b1, 3'b000, 32'h400, 32'h77, 0, 1'b0, 32'h0);
    do_req("err_sbu", 1'b1, 3'b100, 32'h10, 32'h66, 2, 1'b0, 32'h0);
    do_req("err_f3",  1'b0, 3'b011, 32'h8, 32'h0, 0, 1'b0, 32'h0);
    do_req("err_lhu", 1'b0, 3'b101, 32'h1, 32'h0, 0, 1'b0, 32'h0);

    wr_before = wr_seen;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b000;
    req_addr_i = 32'h8; req_wdata_i = 32'h55;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rstmid_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rstmid_memreq", {31'd0, mem_req_o}, 32'd0);
    repeat (4) @(negedge clk);
    chk("rstmid_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    chk("rstmid_no_write", wr_seen, wr_before);
    do_req("lw_8_after", 1'b0, 3'b010, 32'h8, 32'h0, 0, 1'b1, 32'h1122EE44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
